memory_5x8: RTL and testbench
=============================

Name: memory_5x8

Overview:
- 32-word x 8-bit register-file memory with one bidirectional data bus.
- Sits on the processor's shared data bus, addressed by a 5-bit address bus.
- Writes are synchronous; reads are combinational.
- The bus is tri-stated whenever the memory is not sourcing read data.

Parameters:
- DATA_WIDTH, 8, width of each word and of the data bus.
- ADDR_WIDTH, 5, address width.
- MEM_DEPTH, 32 (1<<ADDR_WIDTH), number of words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge except reset.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- sel  input  1  chip select; when 0 the memory neither reads nor writes.
- rd  input  1  read request.
- wr  input  1  write request.
- ld_ir  input  1  instruction-register load strobe from the controller. Accepted but has no effect on memory behaviour.
- data_e  input  1  data-bus enable; qualifies writes.
- address  input  ADDR_WIDTH  word address, 0..31.
- data_out  inout  DATA_WIDTH  shared data bus. Driven by the memory during reads; driven externally during writes.

Behaviour:
- Storage: 32 x 8 flip-flop array, every address 0..31 valid, no wrap or out-of-range case.
- Reset, rst=0, asynchronous:
  - All 32 words clear to 8'h00 immediately, independent of clk.
  - data_out is high-Z while reset is asserted.
  - Writes are ignored while reset is asserted.
- Reset deassertion: synchronous use of rst is not required. The first write can occur on the first rising clk edge after rst returns to 1.
- Write:
  - Condition: rst=1, sel=1, wr=1, data_e=1 at a rising clk edge.
  - Action: mem[address] <= data_out (bus value sampled at the edge).
  - Latency: new value is readable immediately after that edge.
  - wr=1 with data_e=0 or sel=0: no write.
- Read, combinational, zero latency:
  - Output enable: oe = rst & sel & rd & ~wr.
  - When oe=1: data_out = mem[address].
  - When oe=0: data_out = 'z.
  - Address change during a read updates data_out in the same cycle.
- Simultaneous rd=1 and wr=1 with sel=1:
  - Write has priority and the memory does not drive the bus, so there is no contention.
  - A write occurs if data_e=1.
  - The external driver's value is what appears on the bus.
- sel=0: bus is high-Z, array unchanged, regardless of rd/wr/data_e.
- rd=0, wr=0: bus is high-Z.
- Unwritten locations read 8'h00, because of reset.
- Reset mid-operation: contents clear at once. A write in the same cycle as reset assertion is lost.
- ld_ir: no influence on read enable, write enable or bus drive.

Test Plan:
- Reset then write: pulse rst=0, release. With sel=1, wr=1, data_e=1, write 8'hAB to addr 3 and 8'h55 to addr 10 on successive edges. Then with wr=0, rd=1 -> data_out reads 8'hAB at addr 3 and 8'h55 at addr 10 with no extra latency.
- Unwritten read: rd=1, sel=1, addr 20 -> data_out = 8'h00.
- Deselect: sel=0, rd=1, addr 3 -> data_out = 8'hzz. Array unchanged: re-selecting gives 8'hAB.
- Simultaneous rd & wr: sel=1, rd=1, wr=1, data_e=1, external 8'hFF, addr 15 -> no bus contention, bus = 8'hFF. A later pure read of addr 15 returns 8'hFF.
- Write qualifiers: wr=1, sel=1, data_e=0, bus 8'h3C, addr 7 -> addr 7 still reads 8'h00. Repeat with data_e=1, sel=0 -> still 8'h00.
- Async reset: assert rst=0 mid-cycle (not on a clk edge) -> bus high-Z immediately. After release, reading addr 3, 10 and 15 returns 8'h00.

Source files
------------

// File: rtl/memory_5x8.sv
// memory_5x8: 32 x 8 register-file memory on a shared bidirectional data bus.
// Writes are synchronous and sample the bus on the rising clock edge. Reads
// are combinational. The memory drives the bus only while servicing a pure
// read, and leaves it high-Z at all other times.
module memory_5x8 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,       // asynchronous, active-low
  input  logic                  sel,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  ld_ir,
  input  logic                  data_e,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  oe;
  logic                  we;

  // The instruction-register strobe shares the control bundle but has no
  // meaning to the memory itself.
  logic unused_ld_ir;
  assign unused_ld_ir = ld_ir;

  // Write wins over read, so the memory never fights an external driver.
  assign oe = rst & sel & rd & ~wr;
  assign we = rst & sel & wr & data_e;

  // Storage array: cleared asynchronously, written on qualified edges.
  // NOTE: the array is small flip-flop storage, so every word is reset here;
  // a RAM macro would not allow this and would need explicit initialisation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[address] <= data_out;
    end
  end

  // Combinational read onto the shared bus; released to high-Z otherwise.
  assign data_out = oe ? mem[address] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_memory_5x8.sv
// Self-checking bench for memory_5x8. Expected bus values are pushed to a
// scoreboard queue as stimulus is driven and popped when the bus is sampled.
// The bench drives 8'h00 onto the bus wherever the memory must stay off it,
// so that an illegal drive from the memory shows up as a non-zero value.
module tb_memory_5x8;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel, rd, wr, ld_ir, data_e;
  logic [4:0] address;
  logic       drv_en;
  logic [7:0] drv_val;
  wire  [7:0] bus;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_entry_t;

  sb_entry_t  sb[$];
  logic [7:0] model [32];
  int         n_checks = 0;
  int         n_errors = 0;

  assign bus = drv_en ? drv_val : 8'bz;

  always #5 clk = ~clk;

  memory_5x8 dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .rd       (rd),
    .wr       (wr),
    .ld_ir    (ld_ir),
    .data_e   (data_e),
    .address  (address),
    .data_out (bus)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: bus=%h expected=%h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with the current bus value.
  task automatic sample_bus();
    sb_entry_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 8'hxx, 8'h00);
    end else begin
      e = sb.pop_front();
      check(e.tag, bus, e.exp);
    end
  endtask

  // Apply one combinational bus condition after a falling edge, push the
  // expected bus value, sample, then drop write intent before the next edge.
  task automatic drive_and_check(input string tag, input logic s, input logic r,
                                 input logic w, input logic de, input logic [4:0] a,
                                 input logic den, input logic [7:0] dval,
                                 input logic [7:0] exp);
    @(negedge clk);
    sel = s; rd = r; wr = w; data_e = de; address = a;
    drv_en = den; drv_val = dval;
    ld_ir = $urandom_range(0, 1);
    sb.push_back('{tag, exp});
    #2;
    sample_bus();
    wr = 1'b0; data_e = 1'b0; drv_en = 1'b0;
  endtask

  // One write cycle; the model is updated only when the write is qualified.
  task automatic bus_write(input logic [4:0] a, input logic [7:0] v,
                           input logic s, input logic de);
    @(negedge clk);
    sel = s; rd = 1'b0; wr = 1'b1; data_e = de; address = a;
    drv_en = 1'b1; drv_val = v;
    @(posedge clk);
    if (rst && s && de) model[a] = v;
    @(negedge clk);
    wr = 1'b0; data_e = 1'b0; drv_en = 1'b0;
  endtask

  task automatic read_model(input string tag, input logic [4:0] a);
    drive_and_check(tag, 1'b1, 1'b1, 1'b0, 1'b0, a, 1'b0, 8'h00, model[a]);
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; ld_ir = 1'b0; data_e = 1'b0;
    address = '0; drv_en = 1'b0; drv_val = '0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;

    // Reset pulse, then two back-to-back writes.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_write(5'd3, 8'hAB, 1'b1, 1'b1);
    bus_write(5'd10, 8'h55, 1'b1, 1'b1);
    drive_and_check("rd_addr3", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 8'h00, 8'hAB);
    drive_and_check("rd_addr10", 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 1'b0, 8'h00, 8'h55);

    // Address change inside one read cycle updates the bus with no clock.
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; wr = 1'b0; address = 5'd3;
    sb.push_back('{"addr_chg_a", 8'hAB});
    #1 sample_bus();
    address = 5'd10;
    sb.push_back('{"addr_chg_b", 8'h55});
    #1 sample_bus();

    drive_and_check("rd_unwritten", 1'b1, 1'b1, 1'b0, 1'b0, 5'd20, 1'b0, 8'h00, 8'h00);

    // Deselect and idle: memory must release the bus.
    drive_and_check("desel_hiz", 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 8'h00, 8'h00);
    drive_and_check("idle_hiz", 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 8'h00, 8'h00);
    drive_and_check("reselect", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 8'h00, 8'hAB);

    // rd and wr together without data_e: no drive and no write.
    drive_and_check("rdwr_nodrive", 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 8'h00, 8'h00);
    drive_and_check("rdwr_nowrite", 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 8'h00, 8'hAB);

    // Simultaneous rd and wr with data_e: external value on bus and stored.
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; wr = 1'b1; data_e = 1'b1; address = 5'd15;
    drv_en = 1'b1; drv_val = 8'hFF;
    sb.push_back('{"rdwr_bus", 8'hFF});
    #2 sample_bus();
    @(posedge clk);
    model[15] = 8'hFF;
    @(negedge clk);
    wr = 1'b0; data_e = 1'b0; drv_en = 1'b0;
    drive_and_check("rdwr_stored", 1'b1, 1'b1, 1'b0, 1'b0, 5'd15, 1'b0, 8'h00, 8'hFF);

    // Write qualifiers.
    bus_write(5'd7, 8'h3C, 1'b1, 1'b0);
    drive_and_check("no_de_write", 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 8'h00, 8'h00);
    bus_write(5'd7, 8'h3C, 1'b0, 1'b1);
    drive_and_check("no_sel_write", 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 8'h00, 8'h00);

    // Random writes, then read back the whole array against the model.
    for (int i = 0; i < 8; i++) begin
      bus_write(5'($urandom_range(0, 31)), 8'($urandom_range(1, 255)), 1'b1, 1'b1);
    end
    for (int a = 0; a < 32; a++) begin
      read_model($sformatf("sweep_%0d", a), 5'(a));
    end

    // Async reset pulse entirely between clock edges clears the array.
    bus_write(5'd3, 8'hAB, 1'b1, 1'b1);
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; wr = 1'b0; drv_en = 1'b0; address = 5'd3;
    sb.push_back('{"pre_reset", 8'hAB});
    #1 sample_bus();
    #1 rst = 1'b0;
    #1 rst = 1'b1;
    sb.push_back('{"async_clear", 8'h00});
    #1 sample_bus();
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    read_model("post_rst_3", 5'd3);
    read_model("post_rst_10", 5'd10);
    read_model("post_rst_15", 5'd15);

    // A write attempted while reset is held is lost.
    @(negedge clk);
    rst = 1'b0;
    bus_write(5'd5, 8'h77, 1'b1, 1'b1);
    rst = 1'b1;
    read_model("wr_in_reset", 5'd5);

    // First edge after release accepts a write.
    bus_write(5'd5, 8'h5A, 1'b1, 1'b1);
    drive_and_check("first_wr", 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 8'h00, 8'h5A);

    if (sb.size() != 0) check("sb_leftover", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
